// File: rtl/sram_sp_pipe.sv
// Single-port synchronous SRAM: byte enables, valid/ready request side, RD_LAT-deep read pipeline, post-reset zero sweep.
// Optional per-byte even parity with test-only error injection: define SRAM_SP_PIPE_PARITY_EN.
module sram_sp_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
`ifdef SRAM_SP_PIPE_PARITY_EN
    input  logic                par_inject,
`endif
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                err
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_ready;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_data_p [RD_LAT];
    logic [RD_LAT-1:0]   r_vld_p;
    logic [RD_LAT-1:0]   r_err_p;

    logic                w_acc;
    logic                w_wr;
    logic                w_rd;
    logic                w_init_wr;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_rd_par_err;

    // A request coinciding with a reset edge is discarded along with everything else.
    assign w_acc      = en && r_ready && !rst;
    assign w_in_range = ({1'b0, addr} < DEPTH_C);
    assign w_idx      = w_in_range ? addr : '0;
    assign w_wr       = w_acc && wr && w_in_range;
    assign w_rd       = w_acc && !wr;
    assign w_init_wr  = (r_state == S_INIT) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_ready <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef SRAM_SP_PIPE_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_wpar;

    function automatic logic [NB-1:0] f_byte_par(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    assign w_wpar       = f_byte_par(wdata) ^ {NB{par_inject}};
    assign w_rd_par_err = |(f_byte_par(r_mem[w_idx]) ^ r_par[w_idx]);

    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_par[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) r_par[addr][i] <= w_wpar[i];
            end
        end
    end
`else
    assign w_rd_par_err = 1'b0;
`endif

    // p0: array read at the accepting edge; later stages only delay it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rd;
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_data_p[0] <= w_in_range ? r_mem[w_idx] : '0;
        r_err_p[0]  <= !w_in_range || w_rd_par_err;
        for (int i = 1; i < RD_LAT; i++) begin
            r_data_p[i] <= r_data_p[i-1];
            r_err_p[i]  <= r_err_p[i-1];
        end
    end

    // Output: data/err forced to zero whenever no response is being presented.
    assign ready  = r_ready;
    assign rvalid = r_vld_p[RD_LAT-1];
    assign rdata  = rvalid ? r_data_p[RD_LAT-1] : '0;
    assign err    = rvalid && r_err_p[RD_LAT-1];

endmodule

// File: tb/tb_sram_sp_pipe.sv
// Self-checking bench for sram_sp_pipe (DEPTH=12, RD_LAT=3) against an array-based reference model.
module tb_sram_sp_pipe;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 12;
    localparam int RD_LAT = 3;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    be = '0;
    logic          par_inject = 1'b0;
    logic          ready;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          err;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   model_ready = 0;
    logic [31:0] model_mem  [DEPTH];
    logic [3:0]  model_pbad [DEPTH];
    rsp_t exp_q[$];
    rsp_t obs_q[$];

    sram_sp_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
`ifdef SRAM_SP_PIPE_PARITY_EN
        .par_inject(par_inject),
`endif
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rsp_t r;
        if (rvalid === 1'b1) begin
            r.cyc = cyc; r.data = rdata; r.err = err;
            obs_q.push_back(r);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_pbad[i] = '0;
        end
    endtask

    // Drives one request cycle and updates the reference model as the spec says it should behave.
    task automatic drive(input logic e, input logic w, input int a, input logic [31:0] d,
                         input logic [3:0] b, input logic inj);
        rsp_t r;
        en = e; wr = w; addr = a[AW-1:0]; wdata = d; be = b; par_inject = inj;
        if (e && model_ready) begin
            if (w) begin
                if (a < DEPTH) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) begin
                            model_mem[a][8*i +: 8] = d[8*i +: 8];
                            model_pbad[a][i] = inj;
                        end
                    end
                end
            end else begin
                r.cyc = cyc + RD_LAT;
                if (a < DEPTH) begin
                    r.data = model_mem[a];
`ifdef SRAM_SP_PIPE_PARITY_EN
                    r.err = |model_pbad[a];
`else
                    r.err = 1'b0;
`endif
                end else begin
                    r.data = '0;
                    r.err  = 1'b1;
                end
                exp_q.push_back(r);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0; wr = 1'b0; par_inject = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        n = 0;
        while (ready !== 1'b1 && n < DEPTH + 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== DEPTH) begin errors++; $display("FAIL init_len got=%0d want=%0d", n, DEPTH); end
        model_ready = 1;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_init_zero();
        rsp_t e, o;
        for (int a = 0; a < DEPTH; a++) drive(1, 0, a, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL init_zero_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e || e.data !== 32'h0) begin
                errors++; $display("FAIL init_zero cyc/data/err got=%0d/%h/%b want=%0d/00000000/0", o.cyc, o.data, o.err, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_byte_enable();
        rsp_t e, o;
        drive(1, 1, 3, 32'hAABBCCDD, 4'hF, 0);
        drive(1, 1, 3, 32'h11223344, 4'b0101, 0);
        drive(1, 1, 3, 32'hFFFFFFFF, 4'b0000, 0);
        drive(1, 0, 3, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== 1) begin errors++; $display("FAIL byte_en_count got=%0d want=1", obs_q.size()); end
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e || o.data !== 32'hAA22CC44) begin
                errors++; $display("FAIL byte_en cyc/data/err got=%0d/%h/%b want=%0d/aa22cc44/0", o.cyc, o.data, o.err, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        rsp_t e, o;
        for (int a = 0; a < 8; a++) drive(1, 1, a, 32'h01010101 * a, 4'hF, 0);
        for (int a = 0; a < 8; a++) drive(1, 0, a, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== 8) begin errors++; $display("FAIL stream_count got=%0d want=8", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL stream cyc/data/err got=%0d/%h/%b want=%0d/%h/%b", o.cyc, o.data, o.err, e.cyc, e.data, e.err);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_write_then_read();
        rsp_t e, o;
        drive(1, 1, 5, 32'hDEADBEEF, 4'hF, 0);
        drive(1, 0, 5, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== 1) begin errors++; $display("FAIL wtr_count got=%0d want=1", obs_q.size()); end
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e || o.data !== 32'hDEADBEEF) begin
                errors++; $display("FAIL wtr cyc/data/err got=%0d/%h/%b want=%0d/deadbeef/0", o.cyc, o.data, o.err, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_out_of_range();
        rsp_t e, o;
        drive(1, 1, 1, 32'hCAFEF00D, 4'hF, 0);
        drive(1, 1, 13, 32'h12345678, 4'hF, 0);
        drive(1, 0, 13, 32'h0, 4'h0, 0);
        drive(1, 0, 1, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== 2) begin errors++; $display("FAIL oor_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL oor cyc/data/err got=%0d/%h/%b want=%0d/%h/%b", o.cyc, o.data, o.err, e.cyc, e.data, e.err);
            end
        end
        checks++;
        if ({rvalid, rdata, err} !== 34'h0) begin
            errors++; $display("FAIL idle_outputs got rvalid/rdata/err=%b/%h/%b want=0/0/0", rvalid, rdata, err);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        rsp_t e, o;
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                  $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL random cyc/data/err got=%0d/%h/%b want=%0d/%h/%b", o.cyc, o.data, o.err, e.cyc, e.data, e.err);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef SRAM_SP_PIPE_PARITY_EN
    task automatic test_parity();
        rsp_t e, o;
        drive(1, 1, 2, 32'h0F0F0F0F, 4'hF, 1);
        drive(1, 0, 2, 32'h0, 4'h0, 0);
        drive(1, 1, 2, 32'h0F0F0F0F, 4'hF, 0);
        drive(1, 0, 2, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== 2) begin errors++; $display("FAIL parity_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e || o.data !== 32'h0F0F0F0F) begin
                errors++; $display("FAIL parity cyc/data/err got=%0d/%h/%b want=%0d/0f0f0f0f/%b", o.cyc, o.data, o.err, e.cyc, e.err);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    task automatic test_reset_mid();
        rsp_t e, o;
        int n;
        drive(1, 1, 4, 32'h5555AAAA, 4'hF, 0);
        en = 1'b1; wr = 1'b0; addr = AW'(4);
        @(posedge clk); #1;
        en = 1'b0; rst = 1'b1;
        model_ready = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        // Requests held during the sweep must be ignored.
        en = 1'b1; wr = 1'b1; addr = AW'(5); wdata = 32'hFFFFFFFF; be = 4'hF;
        n = 0;
        while (ready !== 1'b1 && n < DEPTH + 8) begin
            @(posedge clk); #1;
            n++;
        end
        en = 1'b0;
        model_ready = 1;
        checks++;
        if (n !== DEPTH) begin errors++; $display("FAIL reinit_len got=%0d want=%0d", n, DEPTH); end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL flushed_read got=%0d responses want=0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
        drive(1, 0, 4, 32'h0, 4'h0, 0);
        drive(1, 0, 5, 32'h0, 4'h0, 0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() !== 2) begin errors++; $display("FAIL post_reset_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e || o.data !== 32'h0) begin
                errors++; $display("FAIL post_reset cyc/data/err got=%0d/%h/%b want=%0d/00000000/0", o.cyc, o.data, o.err, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_byte_enable();
        test_back_to_back();
        test_write_then_read();
        test_out_of_range();
        test_random();
`ifdef SRAM_SP_PIPE_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
